// File: rtl/mdio_controller_if.sv
// Command/response channel bundle for mdio_controller.
// MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN adds the cmd_no_preamble field.
interface mdio_controller_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_c45;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
`ifdef MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN
    logic        cmd_no_preamble;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_wdata,
`ifdef MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN
               cmd_no_preamble,
`endif
               rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_wdata,
`ifdef MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN
               cmd_no_preamble,
`endif
               rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mdio_controller.sv
// MDIO (clause 22 / clause 45) management frame master with MDC generation.
// Optional preamble suppression: define MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN.
module mdio_controller #(
    parameter int CLKS_PER_BIT = 125,
    parameter int GAP_BITS     = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    mdio_controller_if.slave bus,
    output logic            busy,
    output logic            mdc,
    output logic            mdio_o,
    output logic            mdio_t,
    input  logic            mdio_i
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BMAX = (GAP_BITS > 32) ? GAP_BITS : 32;
    localparam int BW   = $clog2(BMAX) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA, GAP, RESP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_cnt, bit_n, last_bit;
    logic          armed;
    logic          accept, in_frame, period_end, no_pre;
    logic          c45_q, c45_n;
    logic [1:0]    op_q, op_n;
    logic [4:0]    phy_q, phy_n, reg_q, reg_n;
    logic [15:0]   wdata_q, wdata_n;
    logic [13:0]   hdr_n;
    logic          rd_n, rd_q;
    logic          o_n, t_n;
    logic          sync1, sync2;
    logic [15:0]   rdata;
    logic          err;

    function automatic logic is_read(input logic c45, input logic [1:0] op);
        return c45 ? op[1] : (op == 2'b10);
    endfunction

`ifdef MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN
    assign no_pre = bus.cmd_no_preamble;
`else
    assign no_pre = 1'b0;
`endif

    assign bus.cmd_ready = armed && (state == IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign in_frame      = (state != IDLE) && (state != RESP);
    assign period_end    = in_frame && (cnt == CNT_LAST);
    assign mdc           = in_frame && (state != GAP) && (cnt >= CNT_HALF);
    assign busy          = (state != IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;

    // The first bit of a frame is launched on the accept edge, so the
    // outgoing-bit logic looks at the incoming command before it is latched.
    assign c45_n   = accept ? bus.cmd_c45   : c45_q;
    assign op_n    = accept ? bus.cmd_op    : op_q;
    assign phy_n   = accept ? bus.cmd_phy   : phy_q;
    assign reg_n   = accept ? bus.cmd_reg   : reg_q;
    assign wdata_n = accept ? bus.cmd_wdata : wdata_q;
    assign hdr_n   = {(c45_n ? 2'b00 : 2'b01), op_n, phy_n, reg_n};
    assign rd_n    = is_read(c45_n, op_n);
    assign rd_q    = is_read(c45_q, op_q);

    always_comb begin
        last_bit = '0;
        case (state)
            PREAMBLE: last_bit = BW'(31);
            HEADER:   last_bit = BW'(13);
            TA:       last_bit = BW'(1);
            DATA:     last_bit = BW'(15);
            GAP:      last_bit = BW'(GAP_BITS - 1);
            default:  last_bit = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (accept) state_n = no_pre ? HEADER : PREAMBLE;
            end
            RESP: begin
                cnt_n = '0;
                bit_n = '0;
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (bit_cnt == last_bit) begin
                        bit_n = '0;
                        case (state)
                            PREAMBLE: state_n = HEADER;
                            HEADER:   state_n = TA;
                            TA:       state_n = DATA;
                            DATA:     state_n = GAP;
                            default:  state_n = RESP;
                        endcase
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    // Line value for the bit period about to start; read frames release from TA.
    always_comb begin
        o_n = 1'b0;
        t_n = 1'b1;
        case (state_n)
            PREAMBLE: begin
                o_n = 1'b1;
                t_n = 1'b0;
            end
            HEADER: begin
                o_n = hdr_n[4'd13 - bit_n[3:0]];
                t_n = 1'b0;
            end
            TA: if (!rd_n) begin
                o_n = ~bit_n[0];
                t_n = 1'b0;
            end
            DATA: if (!rd_n) begin
                o_n = wdata_n[4'd15 - bit_n[3:0]];
                t_n = 1'b0;
            end
            default: begin
                o_n = 1'b0;
                t_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            armed   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c45_q   <= 1'b0;
            op_q    <= '0;
            phy_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            c45_q   <= bus.cmd_c45;
            op_q    <= bus.cmd_op;
            phy_q   <= bus.cmd_phy;
            reg_q   <= bus.cmd_reg;
            wdata_q <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdio_o <= 1'b0;
            mdio_t <= 1'b1;
        end else if (accept || period_end) begin
            mdio_o <= o_n;
            mdio_t <= t_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= mdio_i;
            sync2 <= sync1;
        end
    end

    // A high second turnaround bit means nobody drove the line: no PHY answered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (period_end && rd_q) begin
            if (state == TA && bit_cnt == BW'(1)) err <= sync2;
            if (state == DATA) rdata <= {rdata[14:0], sync2};
        end
    end

endmodule

// File: tb/tb_mdio_controller.sv
// Directed self-checking bench for mdio_controller with a simple PHY model.
// Also covers MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN when that macro is defined.
module tb_mdio_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busy, mdc, mdio_o, mdio_t, mdio_i;
    int          n_assert = 0;
    int          n_fail   = 0;

    int          pre_len = 32;
    logic        phy_en = 1'b0;
    logic [15:0] phy_data = '0;
    int          idx = 0;
    logic [63:0] cap_o = '0;
    logic [63:0] cap_t = '0;
    logic        mdc_d = 1'b0;
    logic        phy_drive = 1'b0;
    logic        phy_val = 1'b1;
    int          lat;
    int          bad;
    int          guard;

    mdio_controller_if bus();

    mdio_controller #(.CLKS_PER_BIT(125), .GAP_BITS(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .mdc     (mdc),
        .mdio_o  (mdio_o),
        .mdio_t  (mdio_t),
        .mdio_i  (mdio_i)
    );

    always #5 clk = ~clk;

    assign mdio_i = !mdio_t ? mdio_o : (phy_drive ? phy_val : 1'b1);

    // PHY model: captures the line on each MDC rise and answers reads after TA.
    always @(negedge clk) begin
        mdc_d <= mdc;
        if (!busy) begin
            idx       <= 0;
            cap_o     <= '0;
            cap_t     <= '0;
            phy_drive <= 1'b0;
            phy_val   <= 1'b1;
        end else if (mdc && !mdc_d) begin
            cap_o <= {cap_o[62:0], mdio_o};
            cap_t <= {cap_t[62:0], mdio_t};
            idx   <= idx + 1;
            if (phy_en && idx == pre_len + 15) begin
                phy_drive <= 1'b1;
                phy_val   <= 1'b0;
            end else if (phy_en && idx >= pre_len + 16 && idx <= pre_len + 31) begin
                phy_drive <= 1'b1;
                phy_val   <= phy_data[4'(pre_len + 31 - idx)];
            end else begin
                phy_drive <= 1'b0;
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                                  input logic [4:0] rg, input logic [15:0] wd);
        @(negedge clk);
        check_output("cmd_ready_before_cmd", {63'd0, bus.cmd_ready}, 64'd1);
        bus.cmd_c45   = c45;
        bus.cmd_op    = op;
        bus.cmd_phy   = phy;
        bus.cmd_reg   = rg;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int l);
        l = 1;
        while (bus.rsp_valid !== 1'b1 && l < 20000) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (l >= 20000) check_output("rsp_timeout", 64'd1, 64'd0);
    endtask

    task automatic release_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check_output("rsp_valid_after_ack", {63'd0, bus.rsp_valid}, 64'd0);
        check_output("busy_after_ack", {63'd0, busy}, 64'd0);
        check_output("cmd_ready_after_ack", {63'd0, bus.cmd_ready}, 64'd1);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_c45   = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_phy   = '0;
        bus.cmd_reg   = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
`ifdef MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN
        bus.cmd_no_preamble = 1'b0;
`endif
        $display("[TB] reset checks");
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        check_output("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check_output("rst_busy", {63'd0, busy}, 64'd0);
        check_output("rst_mdc", {63'd0, mdc}, 64'd0);
        check_output("rst_mdio_o", {63'd0, mdio_o}, 64'd0);
        check_output("rst_mdio_t", {63'd0, mdio_t}, 64'd1);
        check_output("rst_rdata", {48'd0, bus.rsp_rdata}, 64'd0);
        check_output("rst_err", {63'd0, bus.rsp_err}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_output("cmd_ready_before_edge", {63'd0, bus.cmd_ready}, 64'd0);
        @(posedge clk);
        #1 check_output("cmd_ready_first_edge", {63'd0, bus.cmd_ready}, 64'd1);

        $display("[TB] C22 write phy=0C reg=00 data=1140");
        phy_en = 1'b0;
        apply_stimulus(1'b0, 2'b01, 5'h0C, 5'h00, 16'h1140);
        wait_rsp(lat);
        check_output("c22w_latency", 64'(lat), 64'd8126);
        check_output("c22w_line_o", cap_o, {32'hFFFF_FFFF, 32'h5602_1140});
        check_output("c22w_line_t", cap_t, 64'd0);
        check_output("c22w_nbits", 64'(idx), 64'd64);
        check_output("c22w_rdata", {48'd0, bus.rsp_rdata}, 64'd0);
        check_output("c22w_err", {63'd0, bus.rsp_err}, 64'd0);
        release_rsp();

        $display("[TB] C22 read phy=0C reg=02 with PHY data 0141");
        phy_en   = 1'b1;
        phy_data = 16'h0141;
        apply_stimulus(1'b0, 2'b10, 5'h0C, 5'h02, 16'hAAAA);
        wait_rsp(lat);
        check_output("c22r_latency", 64'(lat), 64'd8126);
        check_output("c22r_header", {18'd0, cap_o[63:18]}, {18'd0, 32'hFFFF_FFFF, 14'h1982});
        check_output("c22r_line_t", cap_t, 64'h3FFFF);
        check_output("c22r_rdata", {48'd0, bus.rsp_rdata}, 64'h0141);
        check_output("c22r_err", {63'd0, bus.rsp_err}, 64'd0);
        release_rsp();

        $display("[TB] C22 read phy=1F with no PHY on the line");
        phy_en = 1'b0;
        apply_stimulus(1'b0, 2'b10, 5'h1F, 5'h01, 16'h0000);
        wait_rsp(lat);
        check_output("nophy_rdata", {48'd0, bus.rsp_rdata}, 64'hFFFF);
        check_output("nophy_err", {63'd0, bus.rsp_err}, 64'd1);
        check_output("nophy_line_t", cap_t, 64'h3FFFF);
        release_rsp();

        $display("[TB] C45 address frame with rsp_ready held high throughout");
        bus.rsp_ready = 1'b1;
        apply_stimulus(1'b1, 2'b00, 5'h01, 5'h07, 16'h003C);
        wait_rsp(lat);
        check_output("c45a_latency", 64'(lat), 64'd8126);
        check_output("c45a_line_o", cap_o, {32'hFFFF_FFFF, 32'h009E_003C});
        check_output("c45a_err", {63'd0, bus.rsp_err}, 64'd0);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check_output("c45a_rsp_done", {63'd0, bus.rsp_valid}, 64'd0);
        check_output("c45a_busy_done", {63'd0, busy}, 64'd0);

        $display("[TB] C45 read with ignored second command and delayed rsp_ready");
        phy_en   = 1'b1;
        phy_data = 16'hBEEF;
        apply_stimulus(1'b1, 2'b11, 5'h01, 5'h07, 16'h0000);
        repeat (500) @(posedge clk);
        @(negedge clk);
        bus.cmd_c45   = 1'b0;
        bus.cmd_op    = 2'b01;
        bus.cmd_phy   = 5'h15;
        bus.cmd_reg   = 5'h0A;
        bus.cmd_wdata = 16'h5555;
        bus.cmd_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (bus.cmd_ready !== 1'b0) bad++;
        end
        bus.cmd_valid = 1'b0;
        check_output("mid_frame_cmd_ready", 64'(bad), 64'd0);
        wait_rsp(lat);
        check_output("c45r_header", {18'd0, cap_o[63:18]}, {18'd0, 32'hFFFF_FFFF, 14'h0C27});
        check_output("c45r_line_t", cap_t, 64'h3FFFF);
        check_output("c45r_rdata", {48'd0, bus.rsp_rdata}, 64'hBEEF);
        check_output("c45r_err", {63'd0, bus.rsp_err}, 64'd0);
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF || bus.rsp_err !== 1'b0 ||
                bus.cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check_output("hold_stable", 64'(bad), 64'd0);
        release_rsp();
        bad = 0;
        repeat (300) begin
            @(posedge clk);
            #1 if (busy !== 1'b0) bad++;
        end
        check_output("second_cmd_not_queued", 64'(bad), 64'd0);

        $display("[TB] reset pulse during DATA of a write");
        phy_en = 1'b0;
        apply_stimulus(1'b0, 2'b01, 5'h03, 5'h04, 16'h1234);
        guard = 0;
        while (idx < pre_len + 20 && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 20000) check_output("reset_wait_timeout", 64'd1, 64'd0);
        check_output("pre_reset_mdio_t", {63'd0, mdio_t}, 64'd0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_output("abort_mdio_t", {63'd0, mdio_t}, 64'd1);
        check_output("abort_mdc", {63'd0, mdc}, 64'd0);
        check_output("abort_busy", {63'd0, busy}, 64'd0);
        check_output("abort_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(posedge clk);
            #1 if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_output("abort_no_response", 64'(bad), 64'd0);

`ifdef MDIO_CONTROLLER_PREAMBLE_SUPPRESS_EN
        $display("[TB] C22 write without preamble");
        pre_len = 0;
        bus.cmd_no_preamble = 1'b1;
        apply_stimulus(1'b0, 2'b01, 5'h0C, 5'h00, 16'h1140);
        bus.cmd_no_preamble = 1'b0;
        wait_rsp(lat);
        check_output("nopre_latency", 64'(lat), 64'd4126);
        check_output("nopre_line_o", cap_o, {32'd0, 32'h5602_1140});
        check_output("nopre_first_bits", {62'd0, cap_o[31:30]}, 64'd1);
        check_output("nopre_nbits", 64'(idx), 64'd32);
        release_rsp();
        pre_len = 32;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
